mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the IF-stage fetch port and the MEM-stage data port of the pipelined MIPS core.
- Sequences each access as a req/ack transaction and returns the read data to the requesting stage.
- Generates the pipeline-wide stall while any request is outstanding.
- Sits between the pipeline (PC/IF-ID and EX-MEM/MEM-WB registers) and the external memory model.

Parameters:
- ADDR_W, 32, address width of both ports and memory.
- DATA_W, 32, data width.
- MAX_D_STREAK, 4, consecutive data grants allowed while fetch waits before fetch is forced (range 1..15).
- TIMEOUT, 64, cycles to wait for memAck before aborting (range 2..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- ifReq  in  1  fetch request, held until ifDone.
- ifAddr  in  ADDR_W  fetch address (PC).
- ifData  out  DATA_W  fetched instruction, valid in the ifDone cycle and held afterwards.
- ifDone  out  1  one-cycle completion pulse for fetch.
- dRead  in  1  data load request (MEM-stage memRead).
- dWrite  in  1  data store request (MEM-stage memWrite).
- dAddr  in  ADDR_W  data address (ALU result).
- dWData  in  DATA_W  store data.
- dRData  out  DATA_W  load data, valid in the dDone cycle and held afterwards.
- dDone  out  1  one-cycle completion pulse for data.
- memReq  out  1  memory request, held until memAck.
- memWe  out  1  write enable, qualified by memReq.
- memAddr  out  ADDR_W  latched address.
- memWData  out  DATA_W  latched write data.
- memRData  in  DATA_W  memory read data, sampled with memAck.
- memAck  in  1  memory completion, single cycle.
- stall  out  1  freezes PC, IF/ID and all later pipeline registers.
- err  out  1  sticky timeout flag.

Behaviour:
Reset
- rst low, asynchronous: state IDLE; streak counter and timeout counter cleared.
- memReq, memWe, ifDone, dDone and err are 0; memAddr, memWData, ifData and dRData are 0.
- A reset in the middle of a transaction drops memReq immediately. No done pulse is produced for that transaction.

FSM states: IDLE, D_BUSY, IF_BUSY.

IDLE
- dReq = dRead | dWrite.
- Grant data when dReq is high and either ifReq is low or streak < MAX_D_STREAK. Go to D_BUSY.
- Otherwise, if ifReq is high, grant fetch and go to IF_BUSY.
- On a grant, latch memAddr, memWData and memWe. memWe = dWrite; for a fetch memWe = 0.
- If dRead and dWrite are both high, the access is a write.

Streak counter
- Increments on each data grant made while ifReq is high, saturating at MAX_D_STREAK.
- Clears on every fetch grant.
- Also clears on a data grant made while ifReq is low.

BUSY states
- memReq = 1 from the cycle after the grant until the cycle memAck is seen, inclusive.
- On memAck:
  - register memRData into ifData or dRData; a write leaves dRData unchanged;
  - pulse the matching done output in the next cycle;
  - return to IDLE, with memReq low in that same cycle.
- Minimum latency: request seen in cycle 0, memReq high in cycle 1, memAck in cycle 1, done in cycle 2.
- A new grant is possible in the done cycle, since the FSM is in IDLE then.

Timeout
- The timeout counter runs while in a BUSY state.
- If it reaches TIMEOUT without memAck:
  - set err (sticky until reset);
  - drive the returned data to 32'hDEADBEEF;
  - pulse done, return to IDLE and drop memReq.
- If memAck arrives in the same cycle as the timeout, memAck wins and err stays 0.

Other rules
- A requester deasserting mid-transaction does not abort it: the transaction completes and done still pulses. A requester must not present a new request until it has seen done.
- Any memAck received in IDLE is ignored.
- stall = (ifReq & ~ifDone) | (dReq & ~dDone), combinational, so the pipeline advances exactly in the done cycle.

Decomposition:
- Shared package mips_mem_pkg holds:
  - state encoding (IDLE=2'd0, D_BUSY=2'd1, IF_BUSY=2'd2);
  - the DEAD_DATA constant (32'hDEADBEEF);
  - default ADDR_W/DATA_W.
- One sub-module, arb_wait_counter: clear/enable/terminal-count counter with async active-low reset. It is instantiated twice, once for the streak counter and once for the timeout counter.

Test Plan:
- Lone fetch: ifReq=1, ifAddr=0x40, memory acks 1 cycle after memReq with 0x8C010004 -> memReq=1, memWe=0, memAddr=0x40; ifDone pulses in cycle 2 with ifData=0x8C010004; stall is high in cycles 0-1 and low in cycle 2.
- Simultaneous requests: ifReq=1 and dWrite=1 (dAddr=0x100, dWData=0x55) in the same cycle -> data is granted first (memWe=1, memWData=0x55), dDone pulses, then the fetch is granted; ifDone follows.
- Starvation: dRead held with back-to-back new requests while ifReq=1, MAX_D_STREAK=4 -> exactly 4 data grants, then a fetch grant, then the streak counter is 0.
- Timeout: dRead=1 with memAck never asserted, TIMEOUT=64 -> dDone pulses 64 cycles after memReq rises, dRData=0xDEADBEEF, err=1 and stays 1.
- Reset mid-op: assert rst low while in D_BUSY with memReq=1 -> memReq=0 asynchronously, no dDone; after release, a fresh ifReq completes normally.
- Dual read/write: dRead=1 and dWrite=1 -> memWe=1 and dRData is unchanged after dDone.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the unified-memory port arbiter of the pipelined MIPS core.
//   - Arbiter FSM state encoding.
//   - DEAD_DATA, the value returned to a requester whose access timed out.
//   - Default address and data widths.
package mips_mem_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  localparam logic [31:0] DEAD_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDBusy  = 2'd1,
    StIfBusy = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating up-counter with a terminal-count flag.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset, clears the count
//   clr  : synchronous clear, takes priority over en
//   en   : count up by one; the count holds once it reaches TcVal
//   tc   : high while the count equals TcVal
module arb_wait_counter #(
  parameter int unsigned Width = 8,
  parameter int unsigned TcVal = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [Width-1:0] TcCnt = Width'(TcVal);

  logic [Width-1:0] count_q;

  assign tc = (count_q == TcCnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && !tc) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF fetch port and the MEM data port onto one single-ported,
// variable-latency memory using a req/ack handshake, and stalls the pipeline
// while any request is outstanding.
//   clk, rst                      : clock and asynchronous active-low reset
//   ifReq/ifAddr/ifData/ifDone    : fetch port (request held until ifDone)
//   dRead/dWrite/dAddr/dWData     : data port request (held until dDone)
//   dRData/dDone                  : data port response
//   memReq/memWe/memAddr/memWData : memory request, held until memAck
//   memRData/memAck               : memory response
//   stall                         : pipeline freeze, low exactly in a done cycle
//   err                           : sticky memory timeout flag
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic [DATA_W-1:0] ifData,
  output logic              ifDone,
  input  logic              dRead,
  input  logic              dWrite,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWData,
  output logic [DATA_W-1:0] dRData,
  output logic              dDone,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  input  logic [DATA_W-1:0] memRData,
  input  logic              memAck,
  output logic              stall,
  output logic              err
);

  arb_state_e state_q, state_d;

  logic d_req;
  logic grant_d, grant_if;
  logic finish, timed_out;
  logic streak_tc, timeout_tc;

  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_data_q, d_rdata_q;
  logic              if_done_q, d_done_q, err_q;

  assign d_req = dRead | dWrite;

  always_comb begin
    state_d   = state_q;
    grant_d   = 1'b0;
    grant_if  = 1'b0;
    finish    = 1'b0;
    timed_out = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Data wins unless fetch has already waited through MAX_D_STREAK data grants.
        if (d_req && (!ifReq || !streak_tc)) begin
          grant_d = 1'b1;
          state_d = StDBusy;
        end else if (ifReq) begin
          grant_if = 1'b1;
          state_d  = StIfBusy;
        end
      end
      StDBusy, StIfBusy: begin
        // An ack in the timeout cycle still counts as a normal completion.
        if (memAck) begin
          finish  = 1'b1;
          state_d = StIdle;
        end else if (timeout_tc) begin
          finish    = 1'b1;
          timed_out = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_data_q   <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      if_done_q <= finish && (state_q == StIfBusy);
      d_done_q  <= finish && (state_q == StDBusy);
      if (grant_d || grant_if) begin
        mem_addr_q  <= grant_d ? dAddr : ifAddr;
        mem_wdata_q <= dWData;
        mem_we_q    <= grant_d & dWrite;
      end
      if (finish) begin
        if (state_q == StIfBusy) begin
          if_data_q <= timed_out ? DATA_W'(DEAD_DATA) : memRData;
        end else if (timed_out) begin
          d_rdata_q <= DATA_W'(DEAD_DATA);
        end else if (!mem_we_q) begin
          d_rdata_q <= memRData;
        end
      end
      if (timed_out) begin
        err_q <= 1'b1;
      end
    end
  end

  // Streak counts data grants that made a waiting fetch wait; any fetch grant or
  // an uncontended data grant restarts it.
  arb_wait_counter #(
    .Width(4),
    .TcVal(MAX_D_STREAK)
  ) u_streak (
    .clk(clk),
    .rst(rst),
    .clr(grant_if | (grant_d & ~ifReq)),
    .en (grant_d & ifReq),
    .tc (streak_tc)
  );

  // Count is zero in the first busy cycle, so tc marks the TIMEOUT-th cycle of memReq.
  arb_wait_counter #(
    .Width(8),
    .TcVal(TIMEOUT - 1)
  ) u_timeout (
    .clk(clk),
    .rst(rst),
    .clr(state_q == StIdle),
    .en (state_q != StIdle),
    .tc (timeout_tc)
  );

  assign memReq   = (state_q != StIdle);
  assign memWe    = mem_we_q;
  assign memAddr  = mem_addr_q;
  assign memWData = mem_wdata_q;
  assign ifData   = if_data_q;
  assign dRData   = d_rdata_q;
  assign ifDone   = if_done_q;
  assign dDone    = d_done_q;
  assign err      = err_q;
  assign stall    = (ifReq & ~if_done_q) | (d_req & ~d_done_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int MAXS = 4;
  localparam int TMO  = 64;
  localparam int OwnNone  = 0;
  localparam int OwnData  = 1;
  localparam int OwnFetch = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifReq = 1'b0, ifDone;
  logic [31:0] ifAddr = '0, ifData;
  logic        dRead = 1'b0, dWrite = 1'b0, dDone;
  logic [31:0] dAddr = '0, dWData = '0, dRData;
  logic        memReq, memWe, memAck = 1'b0;
  logic [31:0] memAddr, memWData, memRData = '0;
  logic        stall, err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_D_STREAK(MAXS),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifData(ifData), .ifDone(ifDone),
    .dRead(dRead), .dWrite(dWrite), .dAddr(dAddr), .dWData(dWData),
    .dRData(dRData), .dDone(dDone),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
    .memRData(memRData), .memAck(memAck),
    .stall(stall), .err(err)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level reference: who owns the memory, for how long, and what
  // each port last received.
  int          m_owner, m_age, m_streak;
  logic        m_we, m_err, m_if_done, m_d_done;
  logic [31:0] m_addr, m_wdata, m_if_data, m_d_rdata;

  // Memory responder settings.
  int          ack_delay = 1;   // busy cycle in which memAck comes (0 = never)
  int          next_delay = 1;  // applied to the next granted transaction
  bit          spurious_en = 1'b0;
  bit          rdata_fixed = 1'b1;
  logic [31:0] rdata_val = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = OwnNone; m_age = 0; m_streak = 0;
    m_we = 1'b0; m_err = 1'b0; m_if_done = 1'b0; m_d_done = 1'b0;
    m_addr = '0; m_wdata = '0; m_if_data = '0; m_d_rdata = '0;
  endtask

  task automatic model_step();
    bit want_d;
    if (!rst) begin
      model_reset();
      return;
    end
    m_if_done = 1'b0;
    m_d_done  = 1'b0;
    if (m_owner != OwnNone) begin
      m_age++;
      if (memAck || m_age == TMO) begin
        if (!memAck) m_err = 1'b1;
        if (m_owner == OwnFetch) begin
          m_if_data = memAck ? memRData : 32'hDEADBEEF;
          m_if_done = 1'b1;
        end else begin
          if (!memAck) m_d_rdata = 32'hDEADBEEF;
          else if (!m_we) m_d_rdata = memRData;
          m_d_done = 1'b1;
        end
        m_owner = OwnNone;
      end
    end else begin
      want_d = dRead | dWrite;
      if (want_d && (!ifReq || m_streak < MAXS)) begin
        m_owner = OwnData; m_addr = dAddr; m_we = dWrite; m_wdata = dWData;
        m_streak = ifReq ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
      end else if (ifReq) begin
        m_owner = OwnFetch; m_addr = ifAddr; m_we = 1'b0; m_wdata = dWData;
        m_streak = 0;
      end
      if (m_owner != OwnNone) begin
        m_age = 0;
        ack_delay = next_delay;
      end
    end
  endtask

  task automatic responder();
    if (m_owner != OwnNone) memAck = (ack_delay != 0) && (m_age + 1 == ack_delay);
    else memAck = spurious_en && ($urandom_range(0, 3) == 0);
    memRData = rdata_fixed ? rdata_val : $urandom;
  endtask

  task automatic check_cycle();
    logic exp_stall;
    exp_stall = (ifReq & ~m_if_done) | ((dRead | dWrite) & ~m_d_done);
    chk("memReq", 32'(memReq), 32'(m_owner != OwnNone));
    chk("ifDone", 32'(ifDone), 32'(m_if_done));
    chk("dDone", 32'(dDone), 32'(m_d_done));
    chk("stall", 32'(stall), 32'(exp_stall));
    chk("err", 32'(err), 32'(m_err));
    chk("ifData", ifData, m_if_data);
    chk("dRData", dRData, m_d_rdata);
    if (m_owner != OwnNone) begin
      chk("memWe", 32'(memWe), 32'(m_we));
      chk("memAddr", memAddr, m_addr);
      if (m_we) chk("memWData", memWData, m_wdata);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    responder();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic drain();
    int k = 0;
    while (m_owner != OwnNone && k < 200) begin
      tick();
      k++;
    end
    chk("drain_bound", 32'(m_owner != OwnNone), 32'd0);
    tick();
  endtask

  typedef struct {
    bit          fetch;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    bit          exp_we;
    int          exp_cycle;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n, gcount, d_at, i_at;
    bit done, prev_req;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h40,   32'h0,        1, 32'h8C010004, 32'h8C010004, 1'b0, 2};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h1000, 32'h0,        3, 32'h11112222, 32'h11112222, 1'b0, 4};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h1004, 32'hCAFE0001, 2, 32'h0BADF00D, 32'h11112222, 1'b1, 3};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h1008, 32'h00000077, 1, 32'h33334444, 32'h11112222, 1'b1, 2};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h44,   32'h0,        5, 32'h24420001, 32'h24420001, 1'b0, 6};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h2000, 32'h0,        0, 32'h99999999, 32'hDEADBEEF, 1'b0, 65};

    model_reset();
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Directed single transactions.
    for (int v = 0; v < 6; v++) begin
      next_delay = vecs[v].ack;
      rdata_val  = vecs[v].rdata;
      if (vecs[v].fetch) begin
        ifReq = 1'b1; ifAddr = vecs[v].addr;
      end else begin
        dRead = vecs[v].rd; dWrite = vecs[v].wr; dAddr = vecs[v].addr; dWData = vecs[v].wdata;
      end
      #1;
      chk("vec_stall_c0", 32'(stall), 32'd1);
      n = 0;
      done = 1'b0;
      while (!done && n < 100) begin
        tick();
        n++;
        if (n == 1) begin
          chk("vec_memReq_c1", 32'(memReq), 32'd1);
          chk("vec_memAddr", memAddr, vecs[v].addr);
          chk("vec_memWe", 32'(memWe), 32'(vecs[v].exp_we));
          if (vecs[v].exp_we) chk("vec_memWData", memWData, vecs[v].wdata);
        end
        if (vecs[v].fetch ? ifDone : dDone) begin
          done = 1'b1;
          chk("vec_stall_done", 32'(stall), 32'd0);
          ifReq = 1'b0; dRead = 1'b0; dWrite = 1'b0;
        end
      end
      chk("vec_done_cycle", 32'(n), 32'(vecs[v].exp_cycle));
      chk("vec_data", vecs[v].fetch ? ifData : dRData, vecs[v].exp_data);
      ifReq = 1'b0; dRead = 1'b0; dWrite = 1'b0;
      tick();
    end
    for (int k = 0; k < 5; k++) tick();
    chk("err_sticky", 32'(err), 32'd1);

    // Simultaneous fetch and store: data first, then fetch.
    next_delay = 1;
    rdata_val = 32'hA5A5A5A5;
    ifReq = 1'b1; ifAddr = 32'h80;
    dWrite = 1'b1; dAddr = 32'h100; dWData = 32'h55;
    tick();
    chk("sim_memWe", 32'(memWe), 32'd1);
    chk("sim_memWData", memWData, 32'h55);
    chk("sim_memAddr", memAddr, 32'h100);
    d_at = 99; i_at = 0; n = 0;
    while ((ifReq || dWrite) && n < 40) begin
      tick();
      n++;
      if (m_d_done) begin d_at = n; dWrite = 1'b0; end
      if (m_if_done) begin i_at = n; ifReq = 1'b0; end
    end
    chk("sim_order", 32'(i_at > d_at), 32'd1);
    chk("sim_ifData", ifData, 32'hA5A5A5A5);
    tick();

    // Starvation: both held continuously; fetch wins every fifth grant.
    ifReq = 1'b1; ifAddr = 32'h200;
    dRead = 1'b1; dAddr = 32'h300;
    gcount = 0; prev_req = 1'b0; n = 0;
    while (gcount < 10 && n < 200) begin
      tick();
      n++;
      if (memReq && !prev_req) begin
        chk("starve_grant", memAddr, (gcount % 5 == 4) ? 32'h200 : 32'h300);
        gcount++;
      end
      prev_req = memReq;
    end
    chk("starve_count", 32'(gcount), 32'd10);
    ifReq = 1'b0; dRead = 1'b0;
    drain();

    // Asynchronous reset while a load waits on the memory.
    next_delay = 0;
    dRead = 1'b1; dAddr = 32'h400;
    tick(); tick(); tick();
    chk("rst_pre_memReq", 32'(memReq), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_memReq", 32'(memReq), 32'd0);
    chk("rst_async_dDone", 32'(dDone), 32'd0);
    chk("rst_async_err", 32'(err), 32'd0);
    chk("rst_async_memAddr", memAddr, 32'd0);
    model_reset();
    dRead = 1'b0;
    tick(); tick();
    rst = 1'b1;
    next_delay = 2;
    rdata_val = 32'h12345678;
    ifReq = 1'b1; ifAddr = 32'h500;
    n = 0; done = 1'b0;
    while (!done && n < 20) begin
      tick();
      n++;
      if (ifDone) begin done = 1'b1; ifReq = 1'b0; end
    end
    chk("rst_fetch_cycle", 32'(n), 32'd3);
    chk("rst_fetch_data", ifData, 32'h12345678);
    tick();

    // Random traffic against the reference model.
    spurious_en = 1'b1;
    rdata_fixed = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      next_delay = ($urandom_range(0, 199) == 0) ? 0 : int'($urandom_range(1, 6));
      if (m_if_done && $urandom_range(0, 1) == 1) ifReq = 1'b0;
      if (m_d_done && $urandom_range(0, 1) == 1) begin dRead = 1'b0; dWrite = 1'b0; end
      if (!ifReq && $urandom_range(0, 3) == 0) begin
        ifReq = 1'b1;
        ifAddr = {$urandom_range(0, 255), 2'b00};
      end
      if (!(dRead || dWrite) && $urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0: begin dRead = 1'b1; dWrite = 1'b0; end
          1: begin dRead = 1'b0; dWrite = 1'b1; end
          default: begin dRead = 1'b1; dWrite = 1'b1; end
        endcase
        dAddr = {$urandom_range(256, 511), 2'b00};
        dWData = $urandom;
      end
      tick();
    end
    ifReq = 1'b0; dRead = 1'b0; dWrite = 1'b0;
    spurious_en = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
